// File: rtl/vec_decode_queue.sv
// Buffered vector-instruction decoder: a DEPTH-entry instruction FIFO feeding a registered,
// valid/ready control bundle. Define VEC_DECODE_PERF_EN to add the 32-bit issue_cnt counter.
module vec_decode_queue #(
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = 5,
  parameter int ILL_CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [31:0]             in_instr,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [REG_ADDR_W-1:0]   out_vd,
  output logic [REG_ADDR_W-1:0]   out_vs1,
  output logic [REG_ADDR_W-1:0]   out_vs2,
  output logic [2:0]              out_fu_sel,
  output logic                    out_scalar_op,
  output logic                    out_sub,
  output logic                    out_ld_st,
  output logic                    out_vreg_we,
  output logic                    out_preg_we,
  output logic [1:0]              out_bw_sel,
  output logic [1:0]              out_pred_sel,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    illegal_flag,
  input  logic                    illegal_clr,
`ifdef VEC_DECODE_PERF_EN
  output logic [31:0]             issue_cnt,
`endif
  output logic [ILL_CNT_W-1:0]    illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 5 + 3 * REG_ADDR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [2:0] fu_sel;
    logic       scalar_op;
    logic       sub;
    logic       ld_st;
    logic       vreg_we;
    logic       preg_we;
    logic [1:0] bw_sel;
    logic [1:0] pred_sel;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [4:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      5'b00000: begin c.ld_st = 1'b1; c.vreg_we = 1'b1; end
      5'b00001: c.ld_st = 1'b1;
      5'b00010: c.vreg_we = 1'b1;
      5'b00011: begin c.sub = 1'b1; c.vreg_we = 1'b1; end
      5'b00110: begin c.scalar_op = 1'b1; c.vreg_we = 1'b1; end
      5'b00100: begin c.fu_sel = 3'd2; c.vreg_we = 1'b1; end
      5'b00101: begin c.fu_sel = 3'd2; c.scalar_op = 1'b1; c.vreg_we = 1'b1; end
      5'b00111: begin c.fu_sel = 3'd1; c.vreg_we = 1'b1; end
      5'b10000: begin c.fu_sel = 3'd1; c.sub = 1'b1; c.vreg_we = 1'b1; end
      5'b01000: begin c.fu_sel = 3'd3; c.vreg_we = 1'b1; end
      5'b01001: begin c.fu_sel = 3'd4; c.bw_sel = 2'b00; c.vreg_we = 1'b1; end
      5'b01010: begin c.fu_sel = 3'd4; c.bw_sel = 2'b01; c.vreg_we = 1'b1; end
      5'b01011: begin c.fu_sel = 3'd4; c.bw_sel = 2'b10; c.vreg_we = 1'b1; end
      5'b01100, 5'b01101, 5'b01110, 5'b01111: begin
        c.fu_sel   = 3'd5;
        c.preg_we  = 1'b1;
        c.pred_sel = op[1:0];
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [ILL_CNT_W-1:0] sat_inc(input logic [ILL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [ENT_W-1:0]      fifo_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_p0;
  logic [ENT_W-1:0]      in_entry, head_p0;
  logic [4:0]            head_op;
  logic                  head_legal, nonempty, push, load, ill_pop, pop;
  ctrl_t                 ctrl_p0, ctrl_p1;
  logic [REG_ADDR_W-1:0] vd_p1, vs1_p1, vs2_p1;
  logic                  vld_p1;
  logic                  unused_instr_bits;

  // Only op and the low REG_ADDR_W bits of each register slot are kept in the queue.
  assign in_entry = {in_instr[31:27], in_instr[21 +: REG_ADDR_W],
                     in_instr[16 +: REG_ADDR_W], in_instr[11 +: REG_ADDR_W]};
  assign unused_instr_bits = ^in_instr;

  assign head_p0    = fifo_mem[rd_ptr];
  assign head_op    = head_p0[ENT_W-1 -: 5];
  assign head_legal = (head_op <= 5'b10000);
  assign nonempty   = (count_p0 != '0);
  assign in_ready   = (count_p0 != FULL_CNT);
  assign push       = in_valid & in_ready & ~flush;
  assign load       = nonempty & head_legal & (~vld_p1 | out_ready) & ~flush;
  assign ill_pop    = nonempty & ~head_legal & ~flush;
  assign pop        = load | ill_pop;
  assign ctrl_p0    = decode(head_op);

  // ---- stage p0: instruction queue ----
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_p0 <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_p0 <= count_p0 + 1'b1;
        2'b01:   count_p0 <= count_p0 - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_flag <= 1'b0;
      illegal_cnt  <= '0;
    end else if (ill_pop) begin
      illegal_flag <= 1'b1;
      illegal_cnt  <= sat_inc(illegal_cnt);
    end else if (illegal_clr) begin
      illegal_flag <= 1'b0;
    end
  end

  // ---- stage p1: registered control bundle ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1 <= 1'b1;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_p1 <= '0;
      vd_p1   <= '0;
      vs1_p1  <= '0;
      vs2_p1  <= '0;
    end else if (load) begin
      ctrl_p1 <= ctrl_p0;
      vd_p1   <= head_p0[3*REG_ADDR_W-1 -: REG_ADDR_W];
      vs1_p1  <= head_p0[2*REG_ADDR_W-1 -: REG_ADDR_W];
      vs2_p1  <= head_p0[REG_ADDR_W-1:0];
    end
  end

`ifdef VEC_DECODE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) issue_cnt <= '0;
    else if (vld_p1 && out_ready) issue_cnt <= issue_cnt + 32'd1;
  end
`endif

  assign out_valid     = vld_p1;
  assign out_vd        = vd_p1;
  assign out_vs1       = vs1_p1;
  assign out_vs2       = vs2_p1;
  assign out_fu_sel    = ctrl_p1.fu_sel;
  assign out_scalar_op = ctrl_p1.scalar_op;
  assign out_sub       = ctrl_p1.sub;
  assign out_ld_st     = ctrl_p1.ld_st;
  assign out_vreg_we   = ctrl_p1.vreg_we;
  assign out_preg_we   = ctrl_p1.preg_we;
  assign out_bw_sel    = ctrl_p1.bw_sel;
  assign out_pred_sel  = ctrl_p1.pred_sel;
  assign occupancy     = count_p0;

endmodule

// File: tb/tb_vec_decode_queue.sv
// Scoreboard bench for vec_decode_queue: accepted instructions are queued as expected
// traffic, and a monitor compares every output handshake against a rule-based decode model.
module tb_vec_decode_queue;
  localparam int DEPTH = 4;
  localparam int RW    = 5;
  localparam int ICW   = 8;

  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0;
  logic out_ready = 1'b0, illegal_clr = 1'b0;
  logic [31:0] in_instr = '0;
  logic in_ready, out_valid, out_scalar_op, out_sub, out_ld_st, out_vreg_we, out_preg_we;
  logic illegal_flag;
  logic [RW-1:0] out_vd, out_vs1, out_vs2;
  logic [2:0] out_fu_sel;
  logic [1:0] out_bw_sel, out_pred_sel;
  logic [$clog2(DEPTH):0] occupancy;
  logic [ICW-1:0] illegal_cnt;
`ifdef VEC_DECODE_PERF_EN
  logic [31:0] issue_cnt;
`endif

  vec_decode_queue #(.DEPTH(DEPTH), .REG_ADDR_W(RW), .ILL_CNT_W(ICW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_vd(out_vd), .out_vs1(out_vs1), .out_vs2(out_vs2), .out_fu_sel(out_fu_sel),
    .out_scalar_op(out_scalar_op), .out_sub(out_sub), .out_ld_st(out_ld_st),
    .out_vreg_we(out_vreg_we), .out_preg_we(out_preg_we), .out_bw_sel(out_bw_sel),
    .out_pred_sel(out_pred_sel), .occupancy(occupancy), .illegal_flag(illegal_flag),
    .illegal_clr(illegal_clr),
`ifdef VEC_DECODE_PERF_EN
    .issue_cnt(issue_cnt),
`endif
    .illegal_cnt(illegal_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_ill = 0;
  int hs_total = 0;
  logic [31:0] exp_q[$];

  wire [26:0] act_b = {out_vd, out_vs1, out_vs2, out_fu_sel, out_scalar_op, out_sub,
                       out_ld_st, out_vreg_we, out_preg_we, out_bw_sel, out_pred_sel};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] v);
    return v[31:27] <= 5'd16;
  endfunction

  // Reference decode expressed as membership rules over the opcode number.
  function automatic logic [26:0] exp_bundle(input logic [31:0] v);
    int op;
    logic [2:0] fu;
    logic sc, sb, ls, vw, pw;
    logic [1:0] bw, pr;
    op = int'(v[31:27]);
    fu = 3'd0;
    if (op == 4 || op == 5) fu = 3'd2;
    else if (op == 7 || op == 16) fu = 3'd1;
    else if (op == 8) fu = 3'd3;
    else if (op >= 9 && op <= 11) fu = 3'd4;
    else if (op >= 12 && op <= 15) fu = 3'd5;
    sb = (op == 3 || op == 16);
    sc = (op == 5 || op == 6);
    ls = (op <= 1);
    pw = (op >= 12 && op <= 15);
    vw = (op <= 16) && (op != 1) && !pw;
    bw = (op >= 9 && op <= 11) ? 2'(op - 9) : 2'd0;
    pr = pw ? 2'(op % 4) : 2'd0;
    return {v[25:21], v[20:16], v[15:11], fu, sc, sb, ls, vw, pw, bw, pr};
  endfunction

  function automatic logic [31:0] mk(input int op, input int vd, input int vs1, input int vs2);
    return {5'(op), 1'b0, 5'(vd), 5'(vs1), 5'(vs2), 11'd0};
  endfunction

  // Monitor: compare each consumed bundle and check stability while stalled.
  logic        stall_prev = 1'b0;
  logic [26:0] bundle_prev = '0;
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) chk("hold_stable", act_b, bundle_prev);
      if (out_valid && out_ready) begin
        while (exp_q.size() > 0 && !is_legal(exp_q[0])) begin
          model_ill++;
          void'(exp_q.pop_front());
        end
        if (exp_q.size() == 0) chk("unexpected_bundle", act_b, 27'h7ffffff ^ act_b);
        else chk("bundle", act_b, exp_bundle(exp_q.pop_front()));
        hs_total++;
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_instr);
      stall_prev  = out_valid && !out_ready && !flush;
      bundle_prev = act_b;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] v);
    bit ok;
    ok = 1'b0;
    in_instr = v;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("push_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (occupancy == 0 && !out_valid) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 0, 1);
    step();
  endtask

  task automatic checkpoint(input string tag);
    int lost;
    wait_idle();
    lost = 0;
    while (exp_q.size() > 0) begin
      if (is_legal(exp_q[0])) lost++;
      else model_ill++;
      void'(exp_q.pop_front());
    end
    chk({tag, "_lost"}, lost, 0);
    chk({tag, "_ill_cnt"}, illegal_cnt, (model_ill > 255) ? 255 : model_ill);
`ifdef VEC_DECODE_PERF_EN
    chk({tag, "_issue_cnt"}, issue_cnt, hs_total);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    bit rose;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_ill_flag", illegal_flag, 0);
    chk("rst_ill_cnt", illegal_cnt, 0);
    chk("rst_bundle", act_b, 0);
    step();

    // Single VADD: visible one edge after the push
    out_ready = 1'b1;
    push_one(mk(2, 3, 1, 2));
    @(negedge clk);
    chk("lat_not_early", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("vadd_fields", act_b, {5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0});
    step();
    checkpoint("vadd");

    // Fill: one in the output register plus DEPTH in the queue
    out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) push_one(mk(i + 2, i + 10, i, 31 - i));
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_occupancy", occupancy, DEPTH);
    chk("full_out_valid", out_valid, 1);
    step();
    h0 = hs_total;
    out_ready = 1'b1;
    repeat (DEPTH + 1) @(posedge clk);
    @(negedge clk);
    chk("drain_throughput", hs_total - h0, DEPTH + 1);
    chk("drain_out_valid", out_valid, 0);
    step();
    checkpoint("fill");

    // Illegal head followed by VSLT
    out_ready = 1'b0;
    push_one(32'hF800_0000);
    push_one(mk(15, 4, 5, 6));
    rose = 1'b0;
    for (int i = 0; i < 20 && !rose; i++) begin
      @(negedge clk);
      if (out_valid) rose = 1'b1;
    end
    chk("vslt_valid", rose, 1);
    chk("vslt_fields", act_b, {5'd4, 5'd5, 5'd6, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'b11});
    chk("ill_flag_set", illegal_flag, 1);
    chk("ill_cnt_one", illegal_cnt, 1);
    step();
    checkpoint("illegal");
    illegal_clr = 1'b1;
    step();
    illegal_clr = 1'b0;
    @(negedge clk);
    chk("ill_flag_cleared", illegal_flag, 0);
    chk("ill_cnt_holds", illegal_cnt, 1);
    step();
    push_one(32'hFC00_0000);
    illegal_clr = 1'b1;
    step();
    illegal_clr = 1'b0;
    @(negedge clk);
    chk("ill_clr_vs_pop", illegal_flag, 1);
    step();
    checkpoint("ill_clr");

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = $urandom;
      out_ready = ((c % 64) < 40) ? ($urandom_range(0, 3) != 0) : 1'b0;
      step();
    end
    in_valid = 1'b0;
    checkpoint("random");

    // Flush with a coincident push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(mk(9 + i, i, i + 1, i + 2));
    in_instr = mk(8, 7, 7, 7);
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_occupancy", occupancy, 0);
    chk("flush_out_valid", out_valid, 0);
    step();
    out_ready = 1'b1;
    rose = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) rose = 1'b1;
    end
    chk("flush_discard", rose, 0);
    step();
    checkpoint("flush");

    // Saturation of the illegal counter
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) push_one({5'(17 + (i % 15)), 27'($urandom)});
    checkpoint("saturate");
    chk("sat_value", illegal_cnt, 255);
    chk("sat_flag", illegal_flag, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
